// File: rtl/alu_nibble_seq_if.sv
// alu_nibble_seq_if: request/response bundle between the control unit
// and the nibble-serial ALU sequencer.
interface alu_nibble_seq_if #(
  parameter int WIDTH = 16
);
  logic             start;
  logic [2:0]       op;
  logic [WIDTH-1:0] opa;
  logic [WIDTH-1:0] opb;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             carry_out;
  logic             overflow;
  logic             zero;
  logic             err;

  modport master (
    output start, op, opa, opb,
    input  busy, done, result,
    input  carry_out, overflow, zero, err
  );

  modport slave (
    input  start, op, opa, opb,
    output busy, done, result,
    output carry_out, overflow, zero, err
  );
endinterface

// File: rtl/alu_nibble_seq.sv
// alu_nibble_seq: runs WIDTH-bit ops on a 4-bit ALU slice, one nibble/cycle.
// Optional op counter enabled by defining ALU_SEQ_PERF_EN.
module alu_nibble_seq #(
  parameter int WIDTH = 16
) (
  input  logic              clk,
  input  logic              rst,
  alu_nibble_seq_if.slave   bus,
  output logic [15:0]       perf_ops,
  output logic [3:0]        alu_a,
  output logic [3:0]        alu_b,
  output logic              alu_cin,
  output logic              alu_binv,
  output logic              alu_sel1,
  output logic              alu_sel0,
  output logic [3:0]        alu_less,
  input  logic [3:0]        alu_result,
  input  logic              alu_co
);
  localparam int NIB = WIDTH / 4;
  localparam int CW  = (NIB > 1) ? $clog2(NIB) : 1;

  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SUB = 3'b110;
  localparam logic [2:0] OP_SLT = 3'b111;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             cy_q, cy_d;
  logic [2:0]       op_q, op_d;
  logic [WIDTH-1:0] opa_q, opa_d;
  logic [WIDTH-1:0] opb_q, opb_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             co_q, co_d;
  logic             ov_q, ov_d;
  logic             err_q, err_d;

  logic legal, is_and, is_or, is_slt, arith;
  logic last, s, beff, ov_now;

  assign legal = (bus.op == OP_AND) || (bus.op == OP_OR) ||
                 (bus.op == OP_ADD) || (bus.op == OP_SUB) ||
                 (bus.op == OP_SLT);

  assign is_and = (op_q == OP_AND);
  assign is_or  = (op_q == OP_OR);
  assign is_slt = (op_q == OP_SLT);
  assign arith  = !is_and && !is_or;
  assign last   = (cnt_q == CW'(NIB - 1));

  assign alu_a    = opa_q[4*int'(cnt_q) +: 4];
  assign alu_b    = opb_q[4*int'(cnt_q) +: 4];
  assign alu_binv = (op_q == OP_SUB) || is_slt;
  assign alu_less = 4'b0000;

  // First nibble seeds the carry with binv so SUB/SLT get the +1 of two's complement
  assign alu_cin = arith ? ((cnt_q == '0) ? alu_binv : cy_q) : 1'b0;

  always_comb begin
    {alu_sel1, alu_sel0} = 2'b10;
    unique case (1'b1)
      is_and:  {alu_sel1, alu_sel0} = 2'b00;
      is_or:   {alu_sel1, alu_sel0} = 2'b01;
      default: {alu_sel1, alu_sel0} = 2'b10;
    endcase
  end

  assign s      = alu_result[3];
  assign beff   = opb_q[WIDTH-1] ^ alu_binv;
  assign ov_now = (opa_q[WIDTH-1] == beff) && (s != opa_q[WIDTH-1]);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cy_d    = cy_q;
    op_d    = op_q;
    opa_d   = opa_q;
    opb_d   = opb_q;
    acc_d   = acc_q;
    res_d   = res_q;
    co_d    = co_q;
    ov_d    = ov_q;
    err_d   = err_q;
    unique case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          if (legal) begin
            state_d = S_RUN;
            op_d    = bus.op;
            opa_d   = bus.opa;
            opb_d   = bus.opb;
            cnt_d   = '0;
            cy_d    = 1'b0;
            err_d   = 1'b0;
          end else begin
            state_d = S_DONE;
            err_d   = 1'b1;
            res_d   = '0;
            co_d    = 1'b0;
            ov_d    = 1'b0;
          end
        end
      end
      S_RUN: begin
        acc_d[4*int'(cnt_q) +: 4] = alu_result;
        cy_d = alu_co;
        if (last) begin
          state_d = S_DONE;
          cnt_d   = '0;
          if (is_slt) begin
            res_d    = '0;
            res_d[0] = s ^ ov_now;
            co_d     = 1'b0;
            ov_d     = 1'b0;
          end else begin
            res_d = {alu_result, acc_q[WIDTH-5:0]};
            co_d  = arith ? alu_co : 1'b0;
            ov_d  = arith ? ov_now : 1'b0;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      cy_q    <= 1'b0;
      op_q    <= OP_AND;
      opa_q   <= '0;
      opb_q   <= '0;
      acc_q   <= '0;
      res_q   <= '0;
      co_q    <= 1'b0;
      ov_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cy_q    <= cy_d;
      op_q    <= op_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      acc_q   <= acc_d;
      res_q   <= res_d;
      co_q    <= co_d;
      ov_q    <= ov_d;
      err_q   <= err_d;
    end
  end

  assign bus.busy      = (state_q != S_IDLE);
  assign bus.done      = (state_q == S_DONE);
  assign bus.result    = res_q;
  assign bus.carry_out = co_q;
  assign bus.overflow  = ov_q;
  assign bus.zero      = (res_q == '0);
  assign bus.err       = err_q;

`ifdef ALU_SEQ_PERF_EN
  logic [15:0] perf_q, perf_d;

  assign perf_d = (state_q == S_DONE) ? perf_q + 16'd1 : perf_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) perf_q <= 16'h0000;
    else     perf_q <= perf_d;
  end

  assign perf_ops = perf_q;
`else
  assign perf_ops = 16'h0000;
`endif
endmodule

// File: tb/tb_alu_nibble_seq.sv
// tb_alu_nibble_seq: random + directed ops against a word-level model,
// with a behavioural 4-bit slice closing the loop.
module tb_alu_nibble_seq;
  localparam int W   = 16;
  localparam int NIB = W / 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  alu_nibble_seq_if #(.WIDTH(W)) bus ();

  logic [15:0] perf_ops;
  logic [3:0]  alu_a, alu_b, alu_less, sl_res, bb;
  logic        alu_cin, alu_binv, alu_sel1, alu_sel0, sl_co;
  logic [4:0]  sum;

  alu_nibble_seq #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus),
    .perf_ops   (perf_ops),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_cin    (alu_cin),
    .alu_binv   (alu_binv),
    .alu_sel1   (alu_sel1),
    .alu_sel0   (alu_sel0),
    .alu_less   (alu_less),
    .alu_result (sl_res),
    .alu_co     (sl_co)
  );

  always_comb begin
    bb     = alu_binv ? ~alu_b : alu_b;
    sum    = {1'b0, alu_a} + {1'b0, bb} + {4'b0, alu_cin};
    sl_res = 4'h0;
    sl_co  = 1'b0;
    case ({alu_sel1, alu_sel0})
      2'b00:   sl_res = alu_a & bb;
      2'b01:   sl_res = alu_a | bb;
      2'b10:   begin sl_res = sum[3:0]; sl_co = sum[4]; end
      default: sl_res = 4'h0;
    endcase
  end

  int n_err = 0;
  int n_chk = 0;
  int perf_cnt = 0;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] exp_perf();
`ifdef ALU_SEQ_PERF_EN
    return 16'(perf_cnt);
`else
    return 16'h0000;
`endif
  endfunction

  function automatic void ref_op(input logic [2:0] o,
                                 input logic [W-1:0] a, input logic [W-1:0] b,
                                 output logic [W-1:0] r, output logic c,
                                 output logic v, output logic e);
    logic [W:0] t;
    r = '0; c = 1'b0; v = 1'b0; e = 1'b0;
    case (o)
      3'b000: r = a & b;
      3'b001: r = a | b;
      3'b010: begin
        t = {1'b0, a} + {1'b0, b};
        r = t[W-1:0]; c = t[W];
        v = (a[W-1] == b[W-1]) && (r[W-1] != a[W-1]);
      end
      3'b110: begin
        t = {1'b0, a} + {1'b0, ~b} + 17'd1;
        r = t[W-1:0]; c = t[W];
        v = (a[W-1] != b[W-1]) && (r[W-1] != a[W-1]);
      end
      3'b111: r = ($signed(a) < $signed(b)) ? 16'd1 : 16'd0;
      default: e = 1'b1;
    endcase
  endfunction

  task automatic run_op(input logic [2:0] o, input logic [W-1:0] a,
                        input logic [W-1:0] b, input bit extra);
    logic [W-1:0] er;
    logic ec, ev, ee;
    int n;
    int xdone;
    ref_op(o, a, b, er, ec, ev, ee);
    @(negedge clk);
    bus.start = 1'b1; bus.op = o; bus.opa = a; bus.opb = b;
    @(posedge clk); #1;
    bus.start = 1'b0;
    check("busy_accept", 32'(bus.busy), 32'd1);
    n = 0;
    while (!bus.done && n < 20) begin
      bus.start = (extra && n == 1);
      @(posedge clk); #1;
      n++;
    end
    bus.start = 1'b0;
    check("latency", n, ee ? 0 : NIB);
    check("result", 32'(bus.result), 32'(er));
    check("carry_out", 32'(bus.carry_out), 32'(ec));
    check("overflow", 32'(bus.overflow), 32'(ev));
    check("zero", 32'(bus.zero), 32'(er == '0));
    check("err", 32'(bus.err), 32'(ee));
    @(posedge clk); #1;
    perf_cnt++;
    check("done_pulse", 32'(bus.done), 32'd0);
    check("busy_idle", 32'(bus.busy), 32'd0);
    check("perf_ops", 32'(perf_ops), 32'(exp_perf()));
    check("result_hold", 32'(bus.result), 32'(er));
    if (extra) begin
      xdone = 0;
      repeat (4) begin
        @(posedge clk); #1;
        if (bus.done) xdone++;
      end
      check("extra_done", xdone, 0);
    end
  endtask

  function automatic logic [W-1:0] pick();
    case ($urandom_range(0, 4))
      0: return 16'h8000;
      1: return 16'h7FFF;
      2: return 16'hFFFF;
      default: return 16'($urandom);
    endcase
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    bus.start = 1'b0; bus.op = 3'b000; bus.opa = '0; bus.opb = '0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_done", 32'(bus.done), 32'd0);
    check("rst_result", 32'(bus.result), 32'd0);
    check("rst_zero", 32'(bus.zero), 32'd1);
    check("rst_err", 32'(bus.err), 32'd0);
    check("rst_flags", 32'({bus.carry_out, bus.overflow}), 32'd0);
    check("rst_perf", 32'(perf_ops), 32'd0);
    check("alu_less", 32'(alu_less), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    run_op(3'b010, 16'h7FFF, 16'h0001, 1'b0);
    run_op(3'b110, 16'h0000, 16'h0001, 1'b0);
    run_op(3'b110, 16'h1234, 16'h1234, 1'b0);
    run_op(3'b111, 16'hFFFF, 16'h0001, 1'b0);
    run_op(3'b111, 16'h7FFF, 16'h8000, 1'b0);
    run_op(3'b111, 16'h8000, 16'h7FFF, 1'b0);
    run_op(3'b000, 16'hF0F0, 16'h3C3C, 1'b1);
    run_op(3'b001, 16'hF0F0, 16'h3C3C, 1'b0);
    run_op(3'b011, 16'h1111, 16'h2222, 1'b0);
    run_op(3'b010, 16'hFFFF, 16'h0001, 1'b0);

    @(negedge clk);
    bus.start = 1'b1; bus.op = 3'b010; bus.opa = 16'hABCD; bus.opb = 16'h0101;
    @(posedge clk); #1;
    bus.start = 1'b0;
    @(posedge clk);
    @(posedge clk); #2;
    check("nib2_a", 32'(alu_a), 32'h0B);
    check("nib2_busy", 32'(bus.busy), 32'd1);
    rst = 1'b1;
    #1;
    perf_cnt = 0;
    check("abort_busy", 32'(bus.busy), 32'd0);
    check("abort_done", 32'(bus.done), 32'd0);
    check("abort_result", 32'(bus.result), 32'd0);
    check("abort_perf", 32'(perf_ops), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    run_op(3'b010, 16'h0001, 16'h0001, 1'b0);

    for (int i = 0; i < 40; i++) begin
      run_op(3'($urandom_range(0, 7)), pick(), pick(), 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
